// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the CPU MEM stage: holds the pipeline for LATENCY cycles per access.
// Define DMEM_BYPASS_EN to let a load that hits the last in-range store complete with no stall.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  stall,
  output logic                  done,
  output logic                  fault
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0]    LAST_CNT  = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      count_q;
  logic                  wr_q;
  logic                  in_range_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  done_q;
  logic                  fault_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  req_c;
  logic                  in_range_c;
  logic                  bad_req_c;
  logic                  accept_c;
  logic                  byp_hit_c;
  logic [DATA_WIDTH-1:0] byp_data_c;
  logic [IDX_W-1:0]      lk_idx_c;
  logic                  lk_in_range_c;
  logic [DATA_WIDTH-1:0] rdata_d;

  assign req_c      = req_read | req_write;
  assign in_range_c = ({1'b0, address} < DEPTH_LIM);
  assign bad_req_c  = (req_read & req_write) | ~in_range_c;
  assign accept_c   = (state_q == ST_IDLE) & req_c & ~byp_hit_c;

  // Load value for the access entering DONE: live inputs when LATENCY==1, latched copy otherwise.
  assign lk_idx_c      = (state_q == ST_IDLE) ? address[IDX_W-1:0] : idx_q;
  assign lk_in_range_c = (state_q == ST_IDLE) ? in_range_c : in_range_q;

  always_comb begin
    rdata_d = '0;
    if (lk_in_range_c) begin
      rdata_d = mem[lk_idx_c];
    end
  end

`ifdef DMEM_BYPASS_EN
  logic                  ls_valid_q;
  logic [IDX_W-1:0]      ls_idx_q;
  logic [DATA_WIDTH-1:0] ls_data_q;

  // Only in-range stores are recorded, so an index match plus in-range is a full address match.
  assign byp_hit_c  = (state_q == ST_IDLE) & req_read & ~req_write & ls_valid_q &
                      in_range_c & (address[IDX_W-1:0] == ls_idx_q);
  assign byp_data_c = ls_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ls_valid_q <= 1'b0;
      ls_idx_q   <= '0;
      ls_data_q  <= '0;
    end else if ((state_q == ST_DONE) && wr_q && in_range_q) begin
      ls_valid_q <= 1'b1;
      ls_idx_q   <= idx_q;
      ls_data_q  <= wdata_q;
    end
  end

  assign done      = done_q | byp_hit_c;
  assign read_data = byp_hit_c ? ls_data_q : rdata_q;
`else
  assign byp_hit_c  = 1'b0;
  assign byp_data_c = '0;
  assign done       = done_q;
  assign read_data  = rdata_q;
`endif

  assign stall = (state_q == ST_BUSY) | accept_c;
  assign fault = fault_q;

  // Access sequencer: IDLE latches the request, BUSY counts stall cycles, DONE completes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      wr_q       <= 1'b0;
      in_range_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (byp_hit_c) begin
            rdata_q <= byp_data_c;
          end else if (req_c) begin
            wr_q       <= req_write;
            in_range_q <= in_range_c;
            idx_q      <= address[IDX_W-1:0];
            wdata_q    <= write_data;
            count_q    <= CNT_W'(1);
            if (bad_req_c) begin
              fault_q <= 1'b1;
            end
            if (LATENCY == 1) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              if (!req_write) begin
                rdata_q <= rdata_d;
              end
            end else begin
              state_q <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          count_q <= count_q + CNT_W'(1);
          if (count_q == LAST_CNT) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            if (!wr_q) begin
              rdata_q <= rdata_d;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Store commits at the end of DONE; out-of-range stores and reset-aborted stores never reach here.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == ST_DONE) && wr_q && in_range_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule
